// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at issue,
// parked in pending registers, and committed to HI/LO when the busy countdown expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_we_q, pend_we_d;

  // Arithmetic on the issue-cycle operands
  logic [63:0] mul_s, mul_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r, divu_q, divu_r;
  logic        is_md;

  assign mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign mul_u = {32'b0, A} * {32'b0, B};

  // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign a_mag  = A[31] ? -A : A;
  assign b_mag  = B[31] ? -B : B;
  assign q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
  assign r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
  assign div_q  = (A[31] ^ B[31]) ? -q_mag : q_mag;
  assign div_r  = A[31] ? -r_mag : r_mag;
  assign divu_q = (B == 32'd0) ? 32'd0 : A / B;
  assign divu_r = (B == 32'd0) ? 32'd0 : A % B;

  assign is_md    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign busy     = (state_q == RUN);
  assign occupied = busy | (start & is_md);
  assign HI       = hi_q;
  assign LO       = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_d = mul_s[63:32];
              pend_lo_d = mul_s[31:0];
              pend_we_d = 1'b1;
              cnt_d     = 5'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_MULTU: begin
              pend_hi_d = mul_u[63:32];
              pend_lo_d = mul_u[31:0];
              pend_we_d = 1'b1;
              cnt_d     = 5'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_DIV: begin
              pend_hi_d = div_r;
              pend_lo_d = div_q;
              pend_we_d = (B != 32'd0);
              cnt_d     = 5'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_DIVU: begin
              pend_hi_d = divu_r;
              pend_lo_d = divu_q;
              pend_we_d = (B != 32'd0);
              cnt_d     = 5'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Requests while running are dropped; only the countdown advances.
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a 64-bit arithmetic model of HI/LO.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        busy, occupied;
  logic [31:0] HI, LO;

  int errs = 0;
  int checks = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .occupied(occupied), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Architectural model: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: begin p = 64'(a) * 64'(b); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        p = 64'(sq); exp_lo = p[31:0];
        p = 64'(sr); exp_hi = p[31:0];
      end
      3'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op from idle, measure busy length and check HI/LO afterwards.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n, n_exp;
    bit md, early;
    logic [31:0] old_hi, old_lo;
    md = (o >= 3'd1 && o <= 3'd4);
    n_exp = (o == 3'd1 || o == 3'd2) ? MC : (md ? DC : 0);
    old_hi = exp_hi; old_lo = exp_lo;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    #1 chk({tag, ".occ"}, 64'(occupied), 64'(md));
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
    model(o, a, b);
    n = 0; early = 0;
    while (busy === 1'b1 && n < 64) begin
      if (HI !== old_hi || LO !== old_lo) early = 1;
      @(posedge clk);
      #1 n++;
    end
    chk({tag, ".busy"}, 64'(n), 64'(n_exp));
    chk({tag, ".hold"}, 64'(early), 64'd0);
    chk({tag, ".hilo"}, {HI, LO}, {exp_hi, exp_lo});
  endtask

  initial begin
    int n;
    logic [2:0]  o;
    logic [31:0] a, b;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk("rst", {31'd0, busy, HI, LO}, 64'd0);
    @(negedge clk) reset = 1'b1;

    // Asynchronous reset mid-cycle
    run_op(3'd5, 32'h1111_1111, 32'd0, "mthi0");
    run_op(3'd6, 32'h2222_2222, 32'd0, "mtlo0");
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_rst", {31'd0, busy, HI, LO}, 64'd0);
    exp_hi = 0; exp_lo = 0;
    @(negedge clk) reset = 1'b1;

    // Directed arithmetic
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "divu");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    chk("divovf.k", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op(3'd5, 32'h1234_5678, 32'd0, "mthi");
    run_op(3'd6, 32'h9ABC_DEF0, 32'd0, "mtlo");
    run_op(3'd3, 32'd55, 32'd0, "div0");
    chk("div0.k", {HI, LO}, 64'h1234_5678_9ABC_DEF0);
    run_op(3'd4, 32'd55, 32'd0, "divu0");
    run_op(3'd0, 32'hAAAA_AAAA, 32'd1, "none");
    run_op(3'd7, 32'hAAAA_AAAA, 32'd1, "op7");

    // Requests while busy are dropped
    @(negedge clk) reset = 1'b0;
    exp_hi = 0; exp_lo = 0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd6; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    n = 1;
    @(posedge clk); #1 n++;
    @(negedge clk);
    start = 1'b1; op = 3'd6; A = 32'hDEAD_BEEF; B = 32'd0;
    @(posedge clk); #1 n++;
    @(negedge clk);
    op = 3'd4; A = 32'd9; B = 32'd2;
    @(posedge clk); #1 n++;
    start = 1'b0; op = 3'd0;
    while (busy === 1'b1 && n < 64) begin
      @(posedge clk);
      #1 n++;
    end
    chk("ovl.busy", 64'(n - 1), 64'(MC));
    chk("ovl.hilo", {HI, LO}, 64'h0000_0000_0000_002A);
    repeat (DC + 2) @(posedge clk);
    #1 chk("ovl.idle", {31'd0, busy, HI, LO}, 64'h0000_0000_0000_002A);
    exp_hi = 0; exp_lo = 32'h2A;

    // Reset in the middle of a divide discards the pending result
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("midrst", {31'd0, busy, HI, LO}, 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (DC + 3) @(posedge clk);
    #1 chk("midrst.late", {31'd0, busy, HI, LO}, 64'd0);
    exp_hi = 0; exp_lo = 0;

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(o, a, b, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
